// File: rtl/bbc_keyboard_scanner.sv
// ---------------------------------------------------------------------------
// bbc_keyboard_scanner
//
// Device end of the BBC keyboard / system VIA interface. Holds an
// ROWS x COLS key matrix fed by a host key-event stream. In autoscan mode it
// free-runs a column counter on the 1 MHz strobe and raises CA2 when any key
// in rows 1..ROWS-1 of the current column is down. In manual mode the CPU
// drives the column/row on port A and reads the selected key back on PA7.
//
// Optional feature macro: KBD_LINKS_EN
//   defined   : row 0, columns 2-9 read the startup links (LINKS[9-c]) and
//               key events aimed at those positions are dropped.
//   undefined : LINKS is unused; those positions are ordinary matrix bits.
//
// Ports:
//   clk        in   system clock
//   nRESET     in   synchronous active-low reset
//   clk_en     in   1 MHz scan strobe, one clk wide
//   nKBEN      in   1 = autoscan, 0 = manual probe
//   PA_IN[6:0] in   VIA port A: [3:0] column, [6:4] row
//   PA7        out  key-down flag for the probed row/column
//   CA2        out  keyboard interrupt request (active high)
//   key_valid  in   one-clk key event strobe
//   key_code   in   event position: [6:4] row, [3:0] column
//   key_break  in   1 = release, 0 = press
//   break_key  in   BREAK key state (outside the matrix)
//   nBREAK     out  registered ~break_key
//   LINKS[7:0] in   startup option links
// ---------------------------------------------------------------------------
module bbc_keyboard_scanner #(
    parameter int COLS = 10,
    parameter int ROWS = 8
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       nKBEN,
    input  logic [6:0] PA_IN,
    output logic       PA7,
    output logic       CA2,
    input  logic       key_valid,
    input  logic [6:0] key_code,
    input  logic       key_break,
    input  logic       break_key,
    output logic       nBREAK,
    input  logic [7:0] LINKS
);

    // Key state, one bit per (row, column).
    logic [ROWS-1:0][COLS-1:0] r_matrix;
    logic [3:0]                r_col;

    // Matrix as seen by the readers (links overlaid when enabled).
    logic [ROWS-1:0][COLS-1:0] w_matrix;
    logic [2:0]                w_ev_row;
    logic [3:0]                w_ev_col;
    logic                      w_ev_hit;
    logic                      w_ca2_next;
    logic                      w_pa7_next;
    logic [2:0]                w_pa_row;
    logic [3:0]                w_pa_col;

    assign w_ev_row = key_code[6:4];
    assign w_ev_col = key_code[3:0];
    assign w_pa_row = PA_IN[6:4];
    assign w_pa_col = PA_IN[3:0];

`ifdef KBD_LINKS_EN
    // Link positions are hard-wired from LINKS, so events there are dropped.
    assign w_ev_hit = key_valid
                   && (int'(w_ev_col) < COLS)
                   && (int'(w_ev_row) < ROWS)
                   && !((w_ev_row == 3'd0) && (w_ev_col >= 4'd2) && (w_ev_col <= 4'd9));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_matrix = r_matrix;
        for (int c = 2; c < COLS; c++) begin
            if (c <= 9) begin
                w_matrix[0][c] = LINKS[9-c];
            end
        end
    end
`else
    logic w_unused_links;
    assign w_unused_links = ^LINKS;

    assign w_ev_hit = key_valid
                   && (int'(w_ev_col) < COLS)
                   && (int'(w_ev_row) < ROWS);

    always_comb begin
        w_matrix = r_matrix;
    end
`endif

    // Interrupt request: any key in rows 1.. of the current column. Row 0
    // (SHIFT, CTRL, links) is deliberately left out of the OR.
    always_comb begin
        w_ca2_next = 1'b0;
        if (int'(r_col) < COLS) begin
            for (int r = 1; r < ROWS; r++) begin
                w_ca2_next = w_ca2_next | w_matrix[r][r_col];
            end
        end
    end

    // Manual probe reads straight from PA_IN so the result is one clk behind
    // the port, independent of the column counter.
    always_comb begin
        w_pa7_next = 1'b0;
        if (!nKBEN && (int'(w_pa_col) < COLS) && (int'(w_pa_row) < ROWS)) begin
            w_pa7_next = w_matrix[w_pa_row][w_pa_col];
        end
    end

    // Key matrix. Events are not qualified by clk_en; the last event wins.
    always_ff @(posedge clk) begin
        // NOTE: the matrix is a bank of flops, not RAM, and must come out of
        // reset empty, so it is cleared along with the rest of the state.
        if (!nRESET) begin
            r_matrix <= '0;
        end else if (w_ev_hit) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_matrix[w_ev_row][w_ev_col] <= ~key_break;
        end
    end

    // Column counter: follows PA_IN in manual mode and keeps that value when
    // autoscan resumes.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_col <= 4'd0;
        end else if (!nKBEN) begin
            r_col <= w_pa_col;
        end else if (clk_en) begin
            r_col <= (r_col == 4'(COLS-1)) ? 4'd0 : r_col + 4'd1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            CA2    <= 1'b0;
            PA7    <= 1'b0;
            nBREAK <= 1'b1;
        end else begin
            CA2    <= w_ca2_next;
            PA7    <= w_pa7_next;
            nBREAK <= ~break_key;
        end
    end

endmodule
